// File: rtl/writeback_stage_pkg.sv
// writeback_stage_pkg: shared widths, status/icode/register codes and W register layout.
package writeback_stage_pkg;
    localparam int DATA_W = 64;
    localparam int ICODE_W = 4;
    localparam int STAT_W = 3;
    localparam int REG_W = 4;
    localparam logic [STAT_W-1:0] SAOK = 3'd1;
    localparam logic [STAT_W-1:0] SHLT = 3'd2;
    localparam logic [STAT_W-1:0] SADR = 3'd3;
    localparam logic [STAT_W-1:0] SINS = 3'd4;
    localparam logic [ICODE_W-1:0] INOP = 4'h1;
    localparam logic [REG_W-1:0] RNONE = 4'hF;
    typedef enum logic {RUN, STOP} wb_state_e;
    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [DATA_W-1:0]  val_e;
        logic [DATA_W-1:0]  val_m;
        logic [REG_W-1:0]   dst_e;
        logic [REG_W-1:0]   dst_m;
    } w_reg_t;
    localparam w_reg_t W_BUBBLE = '{stat: SAOK, icode: INOP, val_e: '0, val_m: '0, dst_e: RNONE, dst_m: RNONE};
endpackage

// File: rtl/wb_status_fsm.sv
// wb_status_fsm: sticky RUN/STOP status machine; latches the first non-AOK stat seen in W.
module wb_status_fsm
    import writeback_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [STAT_W-1:0] w_stat,
    output logic              frozen,
    output logic [STAT_W-1:0] cpu_stat,
    output logic              halted
);
    wb_state_e state, state_nxt;
    logic [STAT_W-1:0] lat, lat_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            lat   <= SAOK;
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        if (state == RUN && w_stat != SAOK) begin
            state_nxt = STOP;
            lat_nxt   = w_stat;
        end
        frozen   = state == STOP;
        halted   = state == STOP;
        cpu_stat = state == STOP ? lat : w_stat;
    end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: Y86 W pipeline register, register-file write ports and sticky status.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               W_stall_i,
    input  logic               W_bubble_i,
    input  logic [STAT_W-1:0]  m_stat_i,
    input  logic [ICODE_W-1:0] M_icode_i,
    input  logic [DATA_W-1:0]  M_valE_i,
    input  logic [DATA_W-1:0]  m_valM_i,
    input  logic [REG_W-1:0]   M_dstE_i,
    input  logic [REG_W-1:0]   M_dstM_i,
    output logic [STAT_W-1:0]  W_stat_o,
    output logic [ICODE_W-1:0] W_icode_o,
    output logic [DATA_W-1:0]  W_valE_o,
    output logic [DATA_W-1:0]  W_valM_o,
    output logic [REG_W-1:0]   W_dstE_o,
    output logic [REG_W-1:0]   W_dstM_o,
    output logic               rf_wE_en_o,
    output logic               rf_wM_en_o,
    output logic [REG_W-1:0]   rf_dstE_o,
    output logic [REG_W-1:0]   rf_dstM_o,
    output logic [DATA_W-1:0]  rf_valE_o,
    output logic [DATA_W-1:0]  rf_valM_o,
    output logic [STAT_W-1:0]  cpu_stat_o,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]        retired_cnt_o,
`endif
    output logic               halted_o
);
    w_reg_t w_q;
    logic frozen, ok;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) w_q <= W_BUBBLE;
        else if (!frozen && !W_stall_i)
            w_q <= W_bubble_i ? W_BUBBLE
                              : '{stat: m_stat_i, icode: M_icode_i, val_e: M_valE_i,
                                  val_m: m_valM_i, dst_e: M_dstE_i, dst_m: M_dstM_i};
    end
    wb_status_fsm u_fsm (
        .clk      (clk_i),
        .rst      (rst_i),
        .w_stat   (w_q.stat),
        .frozen   (frozen),
        .cpu_stat (cpu_stat_o),
        .halted   (halted_o)
    );
    assign ok         = !frozen && w_q.stat == SAOK;
    // popq %rsp: dstE == dstM, so only the memory value is written
    assign rf_wE_en_o = ok && w_q.dst_e != RNONE && w_q.dst_e != w_q.dst_m;
    assign rf_wM_en_o = ok && w_q.dst_m != RNONE;
    assign W_stat_o   = w_q.stat;
    assign W_icode_o  = w_q.icode;
    assign W_valE_o   = w_q.val_e;
    assign W_valM_o   = w_q.val_m;
    assign W_dstE_o   = w_q.dst_e;
    assign W_dstM_o   = w_q.dst_m;
    assign rf_dstE_o  = w_q.dst_e;
    assign rf_dstM_o  = w_q.dst_m;
    assign rf_valE_o  = w_q.val_e;
    assign rf_valM_o  = w_q.val_m;
`ifdef WB_RETIRE_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) retired_cnt_o <= '0;
        else if (ok && !W_stall_i && w_q.icode != INOP) retired_cnt_o <= retired_cnt_o + 64'd1;
    end
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: random + directed stimulus, reference model feeds a scoreboard queue.
module tb_writeback_stage;
    import writeback_stage_pkg::*;
    logic clk = 0, rst_i = 1, W_stall_i = 0, W_bubble_i = 0;
    logic [2:0] m_stat_i = 3'd1;
    logic [3:0] M_icode_i = 4'h1, M_dstE_i = 4'hF, M_dstM_i = 4'hF;
    logic [63:0] M_valE_i = 0, m_valM_i = 0;
    logic [2:0] W_stat_o, cpu_stat_o;
    logic [3:0] W_icode_o, W_dstE_o, W_dstM_o, rf_dstE_o, rf_dstM_o;
    logic [63:0] W_valE_o, W_valM_o, rf_valE_o, rf_valM_o;
    logic rf_wE_en_o, rf_wM_en_o, halted_o;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retired_cnt_o;
`endif
    always #5 clk = ~clk;
    writeback_stage dut (
        .clk_i(clk), .rst_i(rst_i), .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .m_stat_i(m_stat_i), .M_icode_i(M_icode_i), .M_valE_i(M_valE_i), .m_valM_i(m_valM_i),
        .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i),
        .W_stat_o(W_stat_o), .W_icode_o(W_icode_o), .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
        .W_dstE_o(W_dstE_o), .W_dstM_o(W_dstM_o),
        .rf_wE_en_o(rf_wE_en_o), .rf_wM_en_o(rf_wM_en_o), .rf_dstE_o(rf_dstE_o), .rf_dstM_o(rf_dstM_o),
        .rf_valE_o(rf_valE_o), .rf_valM_o(rf_valM_o), .cpu_stat_o(cpu_stat_o),
`ifdef WB_RETIRE_CNT_EN
        .retired_cnt_o(retired_cnt_o),
`endif
        .halted_o(halted_o)
    );
    typedef struct {
        logic [2:0] stat; logic [3:0] icode; logic [63:0] ve, vm; logic [3:0] de, dm;
    } instr_t;
    typedef struct {
        instr_t w; bit we_e, we_m, halted; logic [2:0] cpu; logic [63:0] cnt;
    } exp_t;
    int total = 0, bad = 0;
    exp_t sb[$];
    instr_t mw, nop_i;
    bit mh = 0;
    logic [2:0] ml = 3'd1;
    logic [63:0] mc = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input bit r, input bit st, input bit bb, input logic [2:0] s,
                        input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm);
        exp_t e;
        bit oh;
        @(negedge clk);
        rst_i = r; W_stall_i = st; W_bubble_i = bb; m_stat_i = s; M_icode_i = ic;
        M_valE_i = ve; m_valM_i = vm; M_dstE_i = de; M_dstM_i = dm;
        if (r) begin
            mw = nop_i; mh = 0; ml = SAOK; mc = 0;
        end else begin
            oh = mh;
            if (!oh && !st && mw.stat == SAOK && mw.icode != INOP) mc = mc + 1;
            if (!oh && mw.stat != SAOK) begin mh = 1; ml = mw.stat; end
            if (!oh && !st) mw = bb ? nop_i : '{s, ic, ve, vm, de, dm};
        end
        e.w = mw; e.halted = mh; e.cpu = mh ? ml : mw.stat; e.cnt = mc;
        e.we_m = !mh && mw.stat == SAOK && mw.dm != RNONE;
        e.we_e = !mh && mw.stat == SAOK && mw.de != RNONE && mw.de != mw.dm;
        sb.push_back(e);
        if (r) begin
            #1;
            chk("async_halted", halted_o, 0);
            chk("async_cpu", cpu_stat_o, SAOK);
            chk("async_en", {rf_wE_en_o, rf_wM_en_o}, 0);
            chk("async_icode", W_icode_o, INOP);
            chk("async_dst", {W_dstE_o, W_dstM_o}, {RNONE, RNONE});
`ifdef WB_RETIRE_CNT_EN
            chk("async_cnt", retired_cnt_o, 0);
`endif
        end
    endtask
    task automatic ins(input logic [2:0] s, input logic [3:0] ic, input logic [63:0] ve,
                       input logic [63:0] vm, input logic [3:0] de, input logic [3:0] dm);
        step(0, 0, 0, s, ic, ve, vm, de, dm);
    endtask
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("W_stat", W_stat_o, e.w.stat);
            chk("W_icode", W_icode_o, e.w.icode);
            chk("W_valE", W_valE_o, e.w.ve);
            chk("W_valM", W_valM_o, e.w.vm);
            chk("W_dstE", W_dstE_o, e.w.de);
            chk("W_dstM", W_dstM_o, e.w.dm);
            chk("rf_port", {rf_dstE_o, rf_dstM_o, rf_valE_o, rf_valM_o}, {e.w.de, e.w.dm, e.w.ve, e.w.vm});
            chk("rf_wE_en", rf_wE_en_o, e.we_e);
            chk("rf_wM_en", rf_wM_en_o, e.we_m);
            chk("cpu_stat", cpu_stat_o, e.cpu);
            chk("halted", halted_o, e.halted);
`ifdef WB_RETIRE_CNT_EN
            chk("retired_cnt", retired_cnt_o, e.cnt);
`endif
        end
    end
    initial begin
        nop_i = '{SAOK, INOP, 64'd0, 64'd0, RNONE, RNONE};
        mw = nop_i;
        step(1, 0, 0, SAOK, INOP, 0, 0, RNONE, RNONE);
        ins(SAOK, 4'h3, 64'h1234, 0, 4'd3, RNONE);
        ins(SAOK, 4'hB, 64'h108, 64'h55, 4'd4, 4'd4);
        step(0, 1, 1, SAOK, 4'h3, 64'h999, 0, 4'd5, RNONE);
        step(0, 0, 1, SAOK, 4'h3, 64'h777, 0, 4'd6, RNONE);
        ins(SAOK, 4'h6, 64'h42, 0, 4'd1, RNONE);
        step(1, 0, 0, SAOK, 4'h3, 64'h1, 0, 4'd7, RNONE);
        ins(SAOK, 4'h3, 64'h5, 0, 4'd2, RNONE);
        ins(SADR, 4'h5, 0, 64'hAA, RNONE, 4'd2);
        ins(SAOK, 4'h3, 64'h11, 0, 4'd3, RNONE);
        step(0, 1, 1, SAOK, 4'h3, 64'h22, 0, 4'd3, RNONE);
        ins(SAOK, 4'h3, 64'h33, 0, 4'd3, RNONE);
        @(negedge clk);
        chk("sadr_halted", halted_o, 1);
        chk("sadr_cpu", cpu_stat_o, SADR);
        step(1, 0, 0, SAOK, INOP, 0, 0, RNONE, RNONE);
        ins(SAOK, 4'h3, 64'h1, 0, 4'd1, RNONE);
        ins(SAOK, 4'h6, 64'h2, 0, 4'd2, RNONE);
        step(0, 0, 1, SAOK, 4'h3, 64'h9, 0, 4'd9, RNONE);
        ins(SAOK, 4'h3, 64'h3, 0, 4'd3, RNONE);
        repeat (3) step(0, 1, 0, SAOK, 4'h3, 64'h4, 0, 4'd4, RNONE);
        ins(SAOK, 4'h3, 64'h4, 0, 4'd4, RNONE);
        step(0, 0, 1, SAOK, 4'h3, 64'h9, 0, 4'd9, RNONE);
        ins(SAOK, 4'hB, 64'h100, 64'h5, 4'd4, 4'd5);
        ins(SHLT, 4'h0, 0, 0, RNONE, RNONE);
        repeat (3) ins(SAOK, 4'h3, 64'h77, 0, 4'd7, RNONE);
`ifdef WB_RETIRE_CNT_EN
        @(negedge clk);
        chk("cnt_five", retired_cnt_o, 5);
`endif
        for (int i = 0; i < 400; i++) begin
            logic [2:0] s;
            logic [3:0] de, dm;
            s = ($urandom_range(0, 24) == 0) ? 3'($urandom_range(2, 4)) : SAOK;
            de = ($urandom_range(0, 3) == 0) ? RNONE : 4'($urandom_range(0, 14));
            dm = ($urandom_range(0, 1) == 0) ? RNONE : (($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 14)));
            step((mh && $urandom_range(0, 3) == 0) || $urandom_range(0, 79) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, s,
                 4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom}, de, dm);
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final Y86 pipeline stage. Holds the W pipeline register fed by the memory-access stage (m_stat, valM) and the M register (icode, valE, dstE, dstM). Drives the register-file write ports, the W-stage forwarding taps, and a sticky CPU status state machine that freezes the machine on the first non-AOK retirement. An optional retired-instruction counter is compiled in by macro.

## Interface
Parameters: none (widths from `define.v`: `DATA_BUS` 64 b, `ICODE_BUS` 4 b, `STAT_BUS`, `REG_BUS` 4 b).
- clk_i  in  1  pipeline clock
- rst_i  in  1  asynchronous, active-high reset
- W_stall_i  in  1  hold W register (from pipeline control)
- W_bubble_i  in  1  load a bubble into W register
- m_stat_i  in  `STAT_BUS`  status out of memory stage (SADR already merged)
- M_icode_i  in  `ICODE_BUS`  icode from M register
- M_valE_i  in  `DATA_BUS`  ALU result
- m_valM_i  in  `DATA_BUS`  memory read data
- M_dstE_i, M_dstM_i  in  `REG_BUS`  destination register IDs (`RNONE` = no write)
- W_stat_o, W_icode_o, W_valE_o, W_valM_o, W_dstE_o, W_dstM_o  out  as inputs  W register contents (forwarding and pipeline control)
- rf_wE_en_o, rf_wM_en_o  out  1  register-file write enables
- rf_dstE_o, rf_dstM_o  out  `REG_BUS`  write addresses
- rf_valE_o, rf_valM_o  out  `DATA_BUS`  write data
- cpu_stat_o  out  `STAT_BUS`  architectural status
- halted_o  out  1  machine stopped
- retired_cnt_o  out  64  retired instructions (only with `WB_RETIRE_CNT_EN`)

## Operation
- W register update, priority: rst_i > frozen (state STOP) > W_stall_i > W_bubble_i > load from inputs. Stall beats bubble when both are asserted.
- Bubble/reset value: stat `SAOK`, icode `INOP`, valE = valM = 0, dstE = dstM = `RNONE`.
- Write enables are combinational from the W register:
  - rf_wE_en_o = state RUN & W_stat == `SAOK` & W_dstE != `RNONE` & !(W_dstE == W_dstM).
  - rf_wM_en_o = state RUN & W_stat == `SAOK` & W_dstM != `RNONE`.
  - When dstE == dstM (popq %rsp), only the M write occurs, so valM wins.
- rf_dst*/rf_val* mirror W_dst*/W_val* unconditionally.
- Status FSM has two states:
  - RUN (reset state): cpu_stat_o = W_stat_o, halted_o = 0.
  - RUN -> STOP on the clock edge where W_stat_o != `SAOK`. The offending stat is latched.
  - STOP: cpu_stat_o = latched stat, halted_o = 1, W register frozen, both write enables 0. Exit only by reset.
- A non-AOK instruction (SHLT, SADR, SINS) never writes the register file, including in its first cycle in W.

## Timing
- Latency: M/m inputs appear on W_*_o one cycle after the capturing edge. Write enables are valid in the same cycle. The register file writes on the following edge.
- halted_o rises one cycle after a non-AOK entry first appears in W.
- Reset is asynchronous. All outputs take their bubble/RUN values immediately: cpu_stat_o = `SAOK`, halted_o = 0, write enables 0, retired_cnt_o = 0.
- Reset asserted mid-STOP returns the block to RUN with an empty (bubble) W register.
- Stall or bubble asserted while in STOP has no effect.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - retired_cnt_o is present as a 64-bit counter.
  - Increments on each edge where state = RUN, W_stall_i = 0, W_stat == `SAOK` and W_icode != `INOP`.
  - Wraps modulo 2^64. A stalled instruction is counted once, on its leaving edge.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Status codes (`SAOK`/`SHLT`/`SADR`/`SINS`), `INOP`, `RNONE` and the bus widths live in `define.v`. Add `RNONE` and `INOP` there if they are missing. No local literals.
- Sub-module `wb_status_fsm` holds the RUN/STOP state and the latched stat. It outputs `frozen`, cpu_stat_o and halted_o. The W register, write-enable logic and counter stay in the top module.

## Test plan
- Reset mid-run: W_icode_o = `INOP`, dst = `RNONE`, cpu_stat_o = `SAOK`, halted_o = 0, enables 0.
- Load irmovq (dstE = 3, valE = 0x1234, SAOK):
  - Next cycle rf_wE_en_o = 1, rf_dstE_o = 3, rf_valE_o = 0x1234, rf_wM_en_o = 0.
- popq %rsp (dstE = dstM = 4, valE = 0x108, valM = 0x55): rf_wM_en_o = 1 with 0x55, rf_wE_en_o = 0.
- Stall and bubble asserted together with new data on inputs: W register unchanged. Bubble alone: W becomes a NOP.
- m_stat_i = `SADR` with dstM = 2:
  - No write in any cycle; halted_o = 1 the cycle after it reaches W; cpu_stat_o = `SADR`.
  - A following `SAOK` instruction is ignored until reset.
- With `WB_RETIRE_CNT_EN`: 5 valid instructions, 2 bubbles and a 3-cycle stall on one instruction, then halt -> retired_cnt_o = 5.
